gcd_sequencer: RTL and testbench
================================

Name: gcd_sequencer

Overview:
Dedicated hardware sequencer for the GCD-by-repeated-subtraction operation that EC2_microprocessor runs in software.
- Captures two operands through the same Enter/Input handshake the processor uses.
- Owns the A/B operand registers and the subtractor, and steps them until A==B.
- Presents the result with Halt, giving the bench a cycle-accurate reference engine for the processor's user I/O.

Parameters:
WIDTH, 8, operand/result width in bits.
MAX_ITER, 255, maximum subtractions before forced abort; iteration counter width is $clog2(MAX_ITER+1).

Ports:
Clock  input  1  system clock, all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Enter  input  1  level operand strobe; acted on at its rising edge only.
Input  input  WIDTH  operand data, sampled on the cycle the Enter rising edge is detected.
Output  output  WIDTH  GCD result, valid while Halt=1.
Halt  output  1  computation finished, result on Output.
Busy  output  1  high while in CALC.
Error  output  1  iteration limit hit; Output forced to 0.
state  output  2  current FSM state: 0=WAIT_X, 1=WAIT_Y, 2=CALC, 3=DONE.

Behaviour:
- Clock/reset: single clock (Clock). Reset is synchronous, active-high.
- Reset values: state=WAIT_X, A=0, B=0, iteration count=0, enter_q=0, Output=0, Halt=0, Busy=0, Error=0. Reset overrides everything, including mid-CALC.
- Enter edge detect: enter_q<=Enter every cycle. Rising edge (rise) = Enter & ~enter_q.
  - Enter held high for N cycles gives exactly one rise.
  - Enter high across reset release: enter_q resets to 0, so rise fires on the first cycle after reset. Bench must drop Enter before releasing Reset if no capture is wanted.
- WAIT_X:
  - On rise: A<=Input, Output<=0, Error<=0, go to WAIT_Y.
  - Otherwise: hold.
- WAIT_Y:
  - On rise: B<=Input, count<=0, go to CALC; Busy=1 from the next cycle.
- CALC: one decision per cycle, checked in this priority order.
  1. A==0 or B==0: Output<=A|B, go to DONE. gcd(0,n)=n; gcd(0,0)=0 with Error=0.
  2. A==B: Output<=A, go to DONE.
  3. count==MAX_ITER: Output<=0, Error<=1, go to DONE.
  4. A>B: A<=A-B, count<=count+1.
  5. Otherwise: B<=B-A, count<=count+1.
  - Subtraction is unsigned WIDTH-bit; the smaller value is always subtracted from the larger, so no wrap can occur.
- Latency: with k subtractions, Halt rises k+1 cycles after the cycle B is captured.
- DONE:
  - Halt=1, Busy=0. Output and Error held.
  - A rise here is a new X: A<=Input, Output<=0, Halt<=0, Error<=0, go to WAIT_Y.
- Enter in CALC: a rise is ignored, but enter_q still tracks Enter.
- Outputs are registered; Halt/Busy are decoded from the state register. No combinational path from Input/Enter to any output.

Optional Feature:
ENTER_SYNC_EN
- Defined: Enter passes through a 2-flop synchronizer (reset to 0) before edge detection. Captures occur 2 cycles later than without it. All other timing is unchanged.
- Undefined: Enter feeds the edge detector directly. The bench must drive Enter synchronously.

Test Plan:
1. Reset; X=12, then Y=8 -> 2 subtractions; Halt=1 three cycles after Y capture; Output=4; Error=0; state=3.
2. X=37, Y=37 -> Halt one cycle after Y capture; Output=37. X=0, Y=9 -> Output=9. X=0, Y=0 -> Output=0, Error=0.
3. X=255, Y=1, MAX_ITER=255 -> 254 subtractions; Output=1; Error=0. Same operands with MAX_ITER=10 -> Halt 11 cycles after capture, Error=1, Output=0.
4. Reset asserted mid-CALC (X=100, Y=3) -> next cycle state=0, Output=0, Halt=0, Busy=0. Enter held high through reset release -> exactly one capture on the first cycle after release. Enter low at release -> no capture.
5. Enter held high 5 cycles in WAIT_X -> single capture, state=1. A rise during CALC -> ignored, result unchanged.
6. After DONE with Output=4, Enter rise with Input=21, then Y=14 -> Halt drops on the capture cycle; final Output=7. Repeat the GCD comparison over 100 random pairs in 1..127 against a bench model.

Source files
------------

// File: rtl/gcd_sequencer.sv
// GCD-by-repeated-subtraction sequencer with Enter/Input operand handshake.
// Define ENTER_SYNC_EN to pass Enter through a 2-flop synchronizer before edge detection.
module gcd_sequencer #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_ITER = 255
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enter,
   input  logic [WIDTH-1:0] Input,
   output logic [WIDTH-1:0] Output,
   output logic             Halt,
   output logic             Busy,
   output logic             Error,
   output logic [1:0]       state
);

   localparam int unsigned     CW         = $clog2(MAX_ITER + 1);
   localparam logic [CW-1:0]   ITER_LIMIT = CW'(MAX_ITER);

   typedef enum logic [1:0] {
      WAIT_X = 2'd0,
      WAIT_Y = 2'd1,
      CALC   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           cur_state, nxt_state;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic [CW-1:0]    iter_cnt;
   logic             enter_in, enter_q, rise;
   logic             operand_zero, operands_eq, limit_hit;

`ifdef ENTER_SYNC_EN
   logic enter_s1, enter_s2;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         enter_s1 <= 1'b0;
         enter_s2 <= 1'b0;
      end else begin
         enter_s1 <= Enter;
         enter_s2 <= enter_s1;
      end
   end

   assign enter_in = enter_s2;
`else
   assign enter_in = Enter;
`endif

   assign rise         = enter_in & ~enter_q;
   assign operand_zero = (a_reg == '0) || (b_reg == '0);
   assign operands_eq  = (a_reg == b_reg);
   assign limit_hit    = (iter_cnt == ITER_LIMIT);

   always_ff @(posedge Clock) begin
      if (Reset) cur_state <= WAIT_X;
      else       cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = cur_state;
      unique case (cur_state)
         WAIT_X: if (rise) nxt_state = WAIT_Y;
         WAIT_Y: if (rise) nxt_state = CALC;
         CALC:   if (operand_zero || operands_eq || limit_hit) nxt_state = DONE;
         DONE:   if (rise) nxt_state = WAIT_Y;
         default: nxt_state = WAIT_X;
      endcase
   end

   always_comb begin
      Halt  = (cur_state == DONE);
      Busy  = (cur_state == CALC);
      state = cur_state;
   end

   // Decision priority in CALC: zero operand, equality, iteration limit, then subtract.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         a_reg    <= '0;
         b_reg    <= '0;
         iter_cnt <= '0;
         enter_q  <= 1'b0;
         Output   <= '0;
         Error    <= 1'b0;
      end else begin
         enter_q <= enter_in;
         unique case (cur_state)
            WAIT_X, DONE: begin
               if (rise) begin
                  a_reg  <= Input;
                  Output <= '0;
                  Error  <= 1'b0;
               end
            end
            WAIT_Y: begin
               if (rise) begin
                  b_reg    <= Input;
                  iter_cnt <= '0;
               end
            end
            CALC: begin
               if (operand_zero) begin
                  Output <= a_reg | b_reg;
               end else if (operands_eq) begin
                  Output <= a_reg;
               end else if (limit_hit) begin
                  Output <= '0;
                  Error  <= 1'b1;
               end else if (a_reg > b_reg) begin
                  a_reg    <= a_reg - b_reg;
                  iter_cnt <= iter_cnt + 1'b1;
               end else begin
                  b_reg    <= b_reg - a_reg;
                  iter_cnt <= iter_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Self-checking bench for gcd_sequencer: directed cases plus random pairs against a Euclid-based model.
module tb_gcd_sequencer;

   localparam int unsigned LIM_ITER = 10;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       enter_m, enter_l;
   logic [7:0] Input;
   logic [7:0] out_m, out_l;
   logic       halt_m, halt_l, busy_m, busy_l, err_m, err_l;
   logic [1:0] st_m, st_l;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 Clock = ~Clock;

   gcd_sequencer #(.WIDTH(8), .MAX_ITER(255)) dut (
      .Clock(Clock), .Reset(Reset), .Enter(enter_m), .Input(Input),
      .Output(out_m), .Halt(halt_m), .Busy(busy_m), .Error(err_m), .state(st_m)
   );

   gcd_sequencer #(.WIDTH(8), .MAX_ITER(LIM_ITER)) dut_lim (
      .Clock(Clock), .Reset(Reset), .Enter(enter_l), .Input(Input),
      .Output(out_l), .Halt(halt_l), .Busy(busy_l), .Error(err_l), .state(st_l)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Subtraction count equals the sum of Euclid quotients minus one.
   task automatic gcd_model(input int unsigned x, input int unsigned y, input int unsigned lim,
                            output int unsigned res, output bit err, output int unsigned lat);
      int unsigned a, b, t, qsum, k, g;
      if (x == 0 || y == 0) begin
         g = x | y;
         k = 0;
      end else begin
         a = x; b = y; qsum = 0;
         while (b != 0) begin
            qsum += a / b;
            t = a % b;
            a = b;
            b = t;
         end
         g = a;
         k = qsum - 1;
      end
      err = (k > lim);
      res = err ? 0 : g;
      lat = err ? lim + 1 : k + 1;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic set_enter(input bit lim, input logic v);
      if (lim) enter_l = v;
      else     enter_m = v;
   endtask

   task automatic send_x(input bit lim, input logic [7:0] x);
      Input = x;
      set_enter(lim, 1'b1);
      tick();
      set_enter(lim, 1'b0);
      tick();
   endtask

   // Captures Y and returns cycles from the capture edge until Halt.
   task automatic send_y_wait(input bit lim, input logic [7:0] y, output int unsigned lat);
      Input = y;
      set_enter(lim, 1'b1);
      tick();
      set_enter(lim, 1'b0);
      lat = 0;
      while (!(lim ? halt_l : halt_m) && lat < 400) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_and_check(input bit lim, input logic [7:0] x, input logic [7:0] y, input string tag);
      int unsigned lat, exp_res, exp_lat;
      bit          exp_err;
      gcd_model(x, y, lim ? LIM_ITER : 255, exp_res, exp_err, exp_lat);
      send_x(lim, x);
      send_y_wait(lim, y, lat);
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_out"}, lim ? out_l : out_m, exp_res);
      check_eq({tag, "_err"}, lim ? err_l : err_m, exp_err);
      check_eq({tag, "_state"}, lim ? st_l : st_m, 3);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      tick();
   endtask

   initial begin
      int unsigned lat;
      logic [7:0]  rx, ry;

      Reset = 1'b1; enter_m = 1'b0; enter_l = 1'b0; Input = '0;
      tick();
      tick();
      Reset = 1'b0;
      tick();
      check_eq("rst_state", st_m, 0);
      check_eq("rst_out", out_m, 0);
      check_eq("rst_halt", halt_m, 0);
      check_eq("rst_busy", busy_m, 0);
      check_eq("rst_err", err_m, 0);

      // 12,8: Busy on the first CALC cycle, Halt three cycles after capture
      send_x(1'b0, 8'd12);
      check_eq("x_state", st_m, 1);
      Input = 8'd8; enter_m = 1'b1;
      tick();
      enter_m = 1'b0;
      check_eq("calc_busy", busy_m, 1);
      check_eq("calc_state", st_m, 2);
      lat = 0;
      while (!halt_m && lat < 400) begin tick(); lat++; end
      check_eq("g12_8_lat", lat, 3);
      check_eq("g12_8_out", out_m, 4);
      check_eq("g12_8_err", err_m, 0);
      check_eq("g12_8_busy", busy_m, 0);
      check_eq("g12_8_state", st_m, 3);

      run_and_check(1'b0, 8'd37, 8'd37, "g37_37");
      run_and_check(1'b0, 8'd0, 8'd9, "g0_9");
      run_and_check(1'b0, 8'd0, 8'd0, "g0_0");
      run_and_check(1'b0, 8'd255, 8'd1, "g255_1");
      run_and_check(1'b1, 8'd255, 8'd1, "lim255_1");
      run_and_check(1'b1, 8'd20, 8'd10, "lim20_10");

      // Reset during CALC
      send_x(1'b0, 8'd100);
      Input = 8'd3; enter_m = 1'b1;
      tick();
      enter_m = 1'b0;
      tick(); tick(); tick();
      check_eq("mid_busy_pre", busy_m, 1);
      Reset = 1'b1;
      tick();
      check_eq("mid_rst_state", st_m, 0);
      check_eq("mid_rst_out", out_m, 0);
      check_eq("mid_rst_halt", halt_m, 0);
      check_eq("mid_rst_busy", busy_m, 0);

      // Enter held high across reset release captures exactly once
      Input = 8'd55; enter_m = 1'b1;
      tick();
      Reset = 1'b0;
      tick();
      check_eq("hold_rel_state", st_m, 1);
      tick(); tick(); tick();
      check_eq("hold_rel_once", st_m, 1);
      enter_m = 1'b0;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tick(); tick();
      check_eq("low_rel_state", st_m, 0);

      // Enter held 5 cycles in WAIT_X, then a rise during CALC is ignored
      Input = 8'd12; enter_m = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check_eq("held5_state", st_m, 1);
      enter_m = 1'b0;
      tick();
      Input = 8'd8; enter_m = 1'b1;
      tick();
      enter_m = 1'b0;
      tick();
      Input = 8'd99; enter_m = 1'b1;
      tick();
      check_eq("calc_rise_state", st_m, 2);
      lat = 2;
      while (!halt_m && lat < 400) begin tick(); lat++; end
      check_eq("calc_rise_lat", lat, 3);
      check_eq("calc_rise_out", out_m, 4);
      enter_m = 1'b0;
      tick();
      check_eq("calc_rise_hold", st_m, 3);

      // New X from DONE drops Halt on the capture cycle
      Input = 8'd21; enter_m = 1'b1;
      tick();
      enter_m = 1'b0;
      check_eq("redo_halt", halt_m, 0);
      check_eq("redo_state", st_m, 1);
      check_eq("redo_out", out_m, 0);
      tick();
      send_y_wait(1'b0, 8'd14, lat);
      check_eq("g21_14_lat", lat, 3);
      check_eq("g21_14_out", out_m, 7);

      for (int i = 0; i < 100; i++) begin
         rx = 8'($urandom_range(127, 1));
         ry = 8'($urandom_range(127, 1));
         run_and_check(1'b0, rx, ry, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
